inst_axi_rd_bridge: RTL and testbench
=====================================

Name: inst_axi_rd_bridge

Overview:
- Read-only bridge that converts the fetch stage's SRAM-like instruction interface (req/addr_ok/data_ok) into AXI4 AR/R channel transactions.
- Sits directly downstream of the IF stage's inst_sram_* port and upstream of the top-level AXI arbiter.
- Tracks up to MAX_OUTSTANDING in-order reads.
- Returns every accepted request's data exactly once and in order. IF-side cancel/throw logic relies on this.

Parameters:
- MAX_OUTSTANDING, 2, maximum accepted-but-not-returned reads (1..4).
- ARID_VAL, 4'd0, constant value driven on arid.
- CNT_W, 3, width of the outstanding counter; must be at least clog2(MAX_OUTSTANDING+1).

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- inst_sram_req  in  1  fetch request valid.
- inst_sram_wr  in  1  write flag; must be 0 for a request to be accepted.
- inst_sram_size  in  2  transfer size (log2 bytes).
- inst_sram_addr  in  32  physical fetch address.
- inst_sram_addr_ok  out  1  request accepted this cycle.
- inst_sram_data_ok  out  1  read data valid this cycle.
- inst_sram_rdata  out  32  instruction word.
- arid  out  4  constant ARID_VAL.
- araddr  out  32  read address.
- arlen  out  8  constant 0.
- arsize  out  3  {1'b0, latched size}.
- arburst  out  2  constant 2'b01.
- arlock  out  2  constant 0.
- arcache  out  4  constant 0.
- arprot  out  3  constant 0.
- arvalid  out  1  AR valid.
- arready  in  1  AR ready.
- rid  in  4  read id (not checked).
- rdata  in  32  read data.
- rresp  in  2  read response.
- rlast  in  1  last beat.
- rvalid  in  1  R valid.
- rready  out  1  R ready.
- bus_err  out  1  see Optional Feature.

Behaviour:
- Reset (resetn low, asynchronous):
  - arvalid=0, araddr=0, arsize=0, outstanding count=0, bus_err=0.
  - Combinational outputs addr_ok, data_ok and rready evaluate to 0.
  - All in-flight transactions are forgotten; no data_ok is produced for them after reset.
- AR slot: a single register holding {araddr, arsize}. The slot is free when arvalid=0, or when arvalid&&arready occur this cycle.
- Acceptance: addr_ok = req && !wr && slot_free && (cnt < MAX_OUTSTANDING). Combinational, same cycle as the request.
- On addr_ok:
  - the slot loads inst_sram_addr and inst_sram_size;
  - arvalid=1 from the next cycle;
  - cnt increments.
- Earliest AR: arvalid is asserted 1 cycle after addr_ok.
- AR hold: arvalid is held with stable araddr/arsize until arready is sampled high. It then clears unless a new request is accepted in the same cycle, which reloads the slot back-to-back with no bubble.
- R channel: rready = (cnt != 0).
- Read completion:
  - data_ok = rvalid && rready && rlast;
  - rdata is passed through combinationally to inst_sram_rdata;
  - cnt decrements on that handshake.
- Zero latency on return: data_ok is asserted in the same cycle as the R handshake.
- Simultaneous addr_ok and data_ok: cnt is unchanged.
- Limits:
  - cnt==MAX_OUTSTANDING: addr_ok=0 until a completion occurs. A completion in the same cycle does NOT free capacity; acceptance uses the registered cnt.
  - cnt==0 with rvalid=1: rready=0, the beat is not consumed, no data_ok.
- wr=1 request: never accepted (addr_ok stays 0); no AXI activity.
- Ordering: single ARID and in-order R return; no reorder buffer required.
- Counter invariant: cnt never exceeds MAX_OUTSTANDING and never underflows. An assertion-style check must hold in simulation.

Optional Feature:
- Macro: INST_BRIDGE_RRESP_CHK_EN.
- Defined:
  - bus_err is registered and pulses high for exactly 1 cycle after any completing handshake with rresp[1]=1 (SLVERR/DECERR).
  - data_ok and rdata are still delivered unchanged.
- Undefined:
  - bus_err is tied to 0;
  - rresp is ignored.

Test Plan:
- Single fetch:
  - stimulus: req=1, addr=0x1fc00000, size=2, arready=1 always; slave returns rdata=0x3c1d0000 two cycles after AR.
  - required: addr_ok in cycle 0; arvalid/araddr=0x1fc00000 and arsize=3'b010 in cycle 1; data_ok with rdata=0x3c1d0000 exactly once; cnt back to 0.
- Outstanding limit:
  - stimulus: req held high for 4 cycles with addresses 0x0, 0x4, 0x8, 0xc; no R returned.
  - required: exactly 2 addr_ok; requests 3 and 4 wait; both accepted after two R beats; four data_ok in address order.
- AR backpressure:
  - stimulus: arready=0 for 5 cycles after the first accept.
  - required: araddr stays stable and arvalid stays high; second request is not accepted until arready=1; then it is loaded back-to-back.
- Stray R and write reject:
  - stimulus: rvalid=1 with cnt=0; separately, req=1 with wr=1.
  - required: rready=0 and no data_ok; addr_ok=0 and arvalid stays 0.
- Reset mid-flight:
  - stimulus: 2 reads outstanding, then resetn pulsed low asynchronously between clock edges.
  - required: arvalid, rready and data_ok drop to 0 immediately; after release, a new request is accepted with cnt starting at 0.
- Error response (macro defined):
  - stimulus: R returns rresp=2'b10.
  - required: data_ok asserted with the data; bus_err=1 for exactly 1 cycle after the handshake. With the macro undefined, bus_err stays 0.

Source files
------------

// File: rtl/inst_axi_rd_bridge.sv
// Read-only bridge from the fetch stage's SRAM-like port (req/addr_ok/data_ok) to AXI4 AR/R, in-order.
// Optional macro INST_BRIDGE_RRESP_CHK_EN: registered one-cycle bus_err pulse on SLVERR/DECERR responses.
module inst_axi_rd_bridge #(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic [3:0]  ARID_VAL        = 4'd0,
   parameter int unsigned CNT_W           = 3
) (
   input  logic        clk,
   input  logic        resetn,
   // fetch-side SRAM-like port
   input  logic        inst_sram_req,
   input  logic        inst_sram_wr,
   input  logic [1:0]  inst_sram_size,
   input  logic [31:0] inst_sram_addr,
   output logic        inst_sram_addr_ok,
   output logic        inst_sram_data_ok,
   output logic [31:0] inst_sram_rdata,
   // AXI4 read address channel
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [1:0]  arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,
   // AXI4 read data channel
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,
   output logic        bus_err
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             arvalid_q, arvalid_d;
   logic [31:0]      araddr_q, araddr_d;
   logic [1:0]       arsize_q, arsize_d;

   logic slot_free;
   logic accept;
   logic complete;

   // The AR slot can take a new request in the same cycle its current one is handed off.
   assign slot_free = !arvalid_q || arready;

   // Gated by resetn so nothing is accepted while reset is asserted, even with cnt at 0.
   assign accept   = resetn && inst_sram_req && !inst_sram_wr && slot_free
                     && (cnt_q < CNT_W'(MAX_OUTSTANDING));
   assign rready   = resetn && (cnt_q != '0);
   assign complete = rvalid && rready && rlast;

   assign inst_sram_addr_ok = accept;
   assign inst_sram_data_ok = complete;
   assign inst_sram_rdata   = rdata;

   assign arid    = ARID_VAL;
   assign araddr  = araddr_q;
   assign arlen   = 8'd0;
   assign arsize  = {1'b0, arsize_q};
   assign arburst = 2'b01;
   assign arlock  = 2'b00;
   assign arcache = 4'd0;
   assign arprot  = 3'd0;
   assign arvalid = arvalid_q;

   always_comb begin
      // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
      cnt_d     = cnt_q;
      arvalid_d = arvalid_q;
      araddr_d  = araddr_q;
      arsize_d  = arsize_q;

      // Accept and complete together leave the count unchanged.
      case ({accept, complete})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase

      if (accept) begin
         arvalid_d = 1'b1;
         araddr_d  = inst_sram_addr;
         arsize_d  = inst_sram_size;
      end else if (arvalid_q && arready) begin
         arvalid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q     <= '0;
         arvalid_q <= 1'b0;
         araddr_q  <= 32'd0;
         arsize_q  <= 2'd0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values of the others.
         cnt_q     <= cnt_d;
         arvalid_q <= arvalid_d;
         araddr_q  <= araddr_d;
         arsize_q  <= arsize_d;
      end
   end

`ifdef INST_BRIDGE_RRESP_CHK_EN
   logic bus_err_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bus_err_q <= 1'b0;
      end else begin
         bus_err_q <= complete && rresp[1];
      end
   end

   assign bus_err = bus_err_q;
`else
   assign bus_err = 1'b0;
`endif

   // rid is not checked (single ID, in-order); rresp only matters with the error check enabled.
   logic unused_ok;
   assign unused_ok = ^{rid, rresp};

   a_cnt_bound: assert property (@(posedge clk) disable iff (!resetn)
      cnt_q <= CNT_W'(MAX_OUTSTANDING));

   a_cnt_no_underflow: assert property (@(posedge clk) disable iff (!resetn)
      complete |-> (cnt_q != '0));

   a_ar_stable: assert property (@(posedge clk) disable iff (!resetn)
      (arvalid_q && !arready) |=> (arvalid_q && $stable(araddr_q) && $stable(arsize_q)));

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Self-checking bench for inst_axi_rd_bridge: queue-based reference model, directed scenarios, random traffic.
// Define INST_BRIDGE_RRESP_CHK_EN here too when the RTL is built with it.
module tb_inst_axi_rd_bridge;

   localparam int MAXO = 2;

   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_sram_req, inst_sram_wr;
   logic [1:0]  inst_sram_size;
   logic [31:0] inst_sram_addr;
   logic        inst_sram_addr_ok, inst_sram_data_ok;
   logic [31:0] inst_sram_rdata;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst, arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid, arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast, rvalid, rready, bus_err;

   always #5 clk = ~clk;

   inst_axi_rd_bridge #(.MAX_OUTSTANDING(MAXO), .ARID_VAL(4'd0), .CNT_W(3)) dut (
      .clk(clk), .resetn(resetn),
      .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
      .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
      .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
      .inst_sram_rdata(inst_sram_rdata),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .bus_err(bus_err)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Slave memory contents: any address maps to a distinct word; the reset vector holds a known one.
   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a == 32'h1fc0_0000) ? 32'h3c1d_0000 : ((a * 32'h9e37_79b1) ^ 32'h5a5a_5a5a);
   endfunction

   // Reference model: requests accepted but not yet on AR, and requests accepted but not yet returned.
   typedef struct packed { logic [31:0] addr; logic [1:0] size; } ar_t;
   typedef struct { logic [31:0] addr; int due; } sl_t;
   ar_t         ar_q[$];
   logic [31:0] acc_q[$];
   sl_t         sl_q[$];
   logic        m_berr = 1'b0;
   int          cyc = 0;

   // Slave behaviour knobs.
   int rv_pct   = 100;
   int dly_min  = 0;
   int dly_max  = 0;
   int err_mode = 2;  // 0 random rresp, 1 always 2'b10, 2 always OKAY
   bit stray    = 1'b0;

   // Observations from the most recent cycle, used by the literal checks.
   logic        last_aok, last_dok, last_rr, last_arvalid, last_berr;
   logic [31:0] last_araddr;
   logic [2:0]  last_arsize;
   int          n_aok, n_dok;
   logic [31:0] dok_log[$];

   task automatic clear_logs();
      n_aok = 0;
      n_dok = 0;
      dok_log.delete();
   endtask

   task automatic drive_slave();
      if (sl_q.size() != 0 && sl_q[0].due <= cyc && $urandom_range(99) < rv_pct) begin
         rvalid = 1'b1;
         rlast  = 1'b1;
         rdata  = mem(sl_q[0].addr);
         rresp  = (err_mode == 1) ? 2'b10 : (err_mode == 2) ? 2'b00 : 2'($urandom_range(3));
      end else if (stray && acc_q.size() == 0) begin
         rvalid = 1'b1;
         rlast  = 1'b1;
         rdata  = 32'hdead_beef;
         rresp  = 2'b00;
      end else begin
         rvalid = 1'b0;
         rlast  = 1'($urandom_range(1));
         rdata  = $urandom;
         rresp  = 2'($urandom_range(3));
      end
   endtask

   // One clock cycle: called at a negedge with fetch-side inputs already set; returns at the next negedge.
   task automatic cycle();
      logic        e_aok, e_rr, e_dok;
      logic [31:0] seen_araddr, cap_addr;
      logic [1:0]  cap_size, cap_rresp;
      drive_slave();
      #1;
      if (!resetn) begin
         e_aok = 1'b0;
         e_rr  = 1'b0;
         e_dok = 1'b0;
      end else begin
         e_aok = inst_sram_req && !inst_sram_wr && (ar_q.size() == 0 || arready)
                 && (acc_q.size() < MAXO);
         e_rr  = (acc_q.size() != 0);
         e_dok = rvalid && e_rr && rlast;
      end
      check("addr_ok", inst_sram_addr_ok, e_aok);
      check("rready", rready, e_rr);
      check("data_ok", inst_sram_data_ok, e_dok);
      if (e_dok) check("rdata", inst_sram_rdata, mem(acc_q[0]));
      check("arvalid", arvalid, ar_q.size() != 0);
      if (ar_q.size() != 0) begin
         check("araddr", araddr, ar_q[0].addr);
         check("arsize", arsize, {1'b0, ar_q[0].size});
      end
      check("bus_err", bus_err, m_berr);
      check("ar_const", {arid, arlen, arburst, arlock, arcache, arprot},
            {4'd0, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0});

      last_aok     = inst_sram_addr_ok;
      last_dok     = inst_sram_data_ok;
      last_rr      = rready;
      last_arvalid = arvalid;
      last_araddr  = araddr;
      last_arsize  = arsize;
      last_berr    = bus_err;
      n_aok       += int'(inst_sram_addr_ok);
      if (inst_sram_data_ok) begin
         n_dok++;
         dok_log.push_back(inst_sram_rdata);
      end

      seen_araddr = araddr;
      cap_addr    = inst_sram_addr;
      cap_size    = inst_sram_size;
      cap_rresp   = rresp;
      @(posedge clk);
      if (resetn) begin
         if (ar_q.size() != 0 && arready) begin
            sl_q.push_back('{seen_araddr, cyc + int'($urandom_range(dly_max, dly_min))});
            void'(ar_q.pop_front());
         end
         if (e_aok) begin
            ar_q.push_back('{addr: cap_addr, size: cap_size});
            acc_q.push_back(cap_addr);
         end
         if (e_dok) begin
            void'(acc_q.pop_front());
            if (sl_q.size() != 0) void'(sl_q.pop_front());
         end
`ifdef INST_BRIDGE_RRESP_CHK_EN
         m_berr = e_dok && cap_rresp[1];
`else
         m_berr = 1'b0;
`endif
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      inst_sram_req = 1'b0;
      inst_sram_wr  = 1'b0;
      arready       = 1'b1;
      rv_pct        = 100;
      while (acc_q.size() != 0 && n < budget) begin
         cycle();
         n++;
      end
      check("drain_rready_idle", rready, 1'b0);
      check("drain_arvalid_idle", arvalid, 1'b0);
   endtask

   initial begin
      int idx;
      logic b1, b2;

      resetn         = 1'b0;
      inst_sram_req  = 1'b1;
      inst_sram_wr   = 1'b0;
      inst_sram_size = 2'd2;
      inst_sram_addr = 32'h0000_1000;
      arready        = 1'b1;
      rid            = 4'd0;
      rvalid         = 1'b0;
      rlast          = 1'b0;
      rdata          = 32'd0;
      rresp          = 2'b00;
      repeat (2) @(negedge clk);

      // Reset state, with a live request that must not be accepted.
      check("rst_arvalid", arvalid, 1'b0);
      check("rst_araddr", araddr, 32'd0);
      check("rst_arsize", arsize, 3'd0);
      check("rst_addr_ok", inst_sram_addr_ok, 1'b0);
      check("rst_rready", rready, 1'b0);
      check("rst_bus_err", bus_err, 1'b0);
      cycle();
      inst_sram_req = 1'b0;
      resetn = 1'b1;
      cycle();

      // Single fetch: accept in cycle 0, AR in cycle 1, data two cycles after the AR handshake.
      clear_logs();
      dly_min = 2;
      dly_max = 2;
      inst_sram_req  = 1'b1;
      inst_sram_addr = 32'h1fc0_0000;
      inst_sram_size = 2'd2;
      cycle();
      check("sf_addr_ok_c0", last_aok, 1'b1);
      inst_sram_req = 1'b0;
      cycle();
      check("sf_arvalid_c1", last_arvalid, 1'b1);
      check("sf_araddr_c1", last_araddr, 32'h1fc0_0000);
      check("sf_arsize_c1", last_arsize, 3'b010);
      repeat (6) cycle();
      check("sf_data_ok_once", n_dok, 1);
      if (dok_log.size() != 0) check("sf_rdata", dok_log[0], 32'h3c1d_0000);
      check("sf_cnt_zero", last_rr, 1'b0);

      // Outstanding limit: four held requests, no R traffic at first.
      clear_logs();
      dly_min = 0;
      dly_max = 1;
      rv_pct  = 0;
      idx     = 0;
      for (int i = 0; i < 4; i++) begin
         inst_sram_req  = 1'b1;
         inst_sram_addr = 32'(4 * idx);
         cycle();
         if (last_aok) idx++;
      end
      check("lim_two_accepts", n_aok, 2);
      rv_pct = 100;
      for (int n = 0; n < 60 && !(idx == 4 && acc_q.size() == 0); n++) begin
         inst_sram_req  = (idx < 4);
         inst_sram_addr = 32'(4 * idx);
         cycle();
         if (last_aok) idx++;
      end
      inst_sram_req = 1'b0;
      check("lim_four_accepts", n_aok, 4);
      check("lim_four_data_ok", n_dok, 4);
      for (int i = 0; i < 4 && i < dok_log.size(); i++)
         check("lim_order", dok_log[i], mem(32'(4 * i)));
      drain(50);

      // AR backpressure: first request parked on AR, second waits until arready.
      clear_logs();
      inst_sram_req  = 1'b1;
      inst_sram_addr = 32'h0000_0100;
      arready        = 1'b0;
      cycle();
      check("bp_accept_first", last_aok, 1'b1);
      inst_sram_addr = 32'h0000_0104;
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("bp_arvalid_held", last_arvalid, 1'b1);
         check("bp_araddr_stable", last_araddr, 32'h0000_0100);
         check("bp_second_waits", last_aok, 1'b0);
      end
      arready = 1'b1;
      cycle();
      check("bp_b2b_accept", last_aok, 1'b1);
      inst_sram_req = 1'b0;
      cycle();
      check("bp_b2b_arvalid", last_arvalid, 1'b1);
      check("bp_b2b_araddr", last_araddr, 32'h0000_0104);
      drain(50);

      // Stray R beat with nothing outstanding, then write requests.
      clear_logs();
      stray = 1'b1;
      repeat (3) cycle();
      check("stray_rready", last_rr, 1'b0);
      check("stray_no_data_ok", n_dok, 0);
      stray          = 1'b0;
      inst_sram_req  = 1'b1;
      inst_sram_wr   = 1'b1;
      inst_sram_addr = 32'h0000_0500;
      repeat (3) cycle();
      check("wr_no_addr_ok", n_aok, 0);
      check("wr_no_arvalid", last_arvalid, 1'b0);
      inst_sram_req = 1'b0;
      inst_sram_wr  = 1'b0;

      // Reset mid-flight with two reads outstanding.
      clear_logs();
      rv_pct = 0;
      idx    = 0;
      for (int n = 0; n < 10 && n_aok < 2; n++) begin
         inst_sram_req  = 1'b1;
         inst_sram_addr = 32'h0000_0200 + 32'(4 * idx);
         cycle();
         if (last_aok) idx++;
      end
      check("rf_two_outstanding", n_aok, 2);
      inst_sram_req  = 1'b1;
      inst_sram_addr = 32'h0000_0208;
      rvalid = 1'b1;
      rlast  = 1'b1;
      rdata  = 32'h1111_1111;
      rresp  = 2'b00;
      #2 resetn = 1'b0;
      #1;
      check("rf_arvalid_drop", arvalid, 1'b0);
      check("rf_rready_drop", rready, 1'b0);
      check("rf_data_ok_drop", inst_sram_data_ok, 1'b0);
      check("rf_addr_ok_low", inst_sram_addr_ok, 1'b0);
      check("rf_araddr_clear", araddr, 32'd0);
      check("rf_bus_err_clear", bus_err, 1'b0);
      ar_q.delete();
      acc_q.delete();
      sl_q.delete();
      m_berr = 1'b0;
      @(negedge clk);
      repeat (2) cycle();
      resetn         = 1'b1;
      rv_pct         = 100;
      inst_sram_addr = 32'h0000_0300;
      cycle();
      check("rf_new_accept", last_aok, 1'b1);
      inst_sram_addr = 32'h0000_0304;
      cycle();
      check("rf_cnt_from_zero", last_aok, 1'b1);
      check("rf_rready_one", last_rr, 1'b1);
      drain(50);

      // Error response.
      clear_logs();
      err_mode       = 1;
      inst_sram_req  = 1'b1;
      inst_sram_addr = 32'h0000_0400;
      cycle();
      inst_sram_req = 1'b0;
      for (int n = 0; n < 20 && n_dok == 0; n++) cycle();
      check("err_data_ok", n_dok, 1);
      if (dok_log.size() != 0) check("err_rdata", dok_log[0], mem(32'h0000_0400));
      cycle();
      b1 = last_berr;
      cycle();
      b2 = last_berr;
`ifdef INST_BRIDGE_RRESP_CHK_EN
      check("err_pulse_hi", b1, 1'b1);
`else
      check("err_pulse_hi", b1, 1'b0);
`endif
      check("err_pulse_lo", b2, 1'b0);
      drain(50);

      // Randomized traffic.
      err_mode = 0;
      stray    = 1'b1;
      dly_min  = 0;
      dly_max  = 3;
      for (int n = 0; n < 3000; n++) begin
         inst_sram_req  = ($urandom_range(99) < 60);
         inst_sram_wr   = ($urandom_range(99) < 10);
         inst_sram_size = 2'($urandom_range(3));
         inst_sram_addr = {$urandom} & 32'hffff_fffc;
         arready        = ($urandom_range(99) < 70);
         rv_pct         = 60;
         cycle();
      end
      stray = 1'b0;
      drain(200);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
